// File: rtl/ttl_timed_sequencer.sv
// Timestamped TTL event scheduler: queues {ts, mask, value} words and applies each
// one to the TTL lines when the free-running timebase reaches its timestamp.
module ttl_timed_sequencer #(
  parameter int DATA_WIDTH = 128,
  parameter int TTL_WIDTH  = 32,
  parameter int TS_WIDTH   = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        s_axi_aclk,
  input  logic                        s_axi_aresetn,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        run,
  input  logic                        clear,
  output logic [TTL_WIDTH-1:0]        ttl_out,
  output logic [TS_WIDTH-1:0]         time_now,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        late_pulse,
  output logic [15:0]                 late_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic [TS_WIDTH-1:0]     time_q;
  logic [TTL_WIDTH-1:0]    ttl_q;
  logic                    late_q;
  logic [15:0]             late_cnt_q;

  logic                    full, push, fire, late;
  logic [DATA_WIDTH-1:0]   head;
  logic [TTL_WIDTH-1:0]    head_val, head_mask;
  logic [TS_WIDTH-1:0]     head_ts;

  assign head      = mem_q[rd_ptr_q];
  assign head_val  = head[TTL_WIDTH-1:0];
  assign head_mask = head[2*TTL_WIDTH-1:TTL_WIDTH];
  assign head_ts   = head[2*TTL_WIDTH+TS_WIDTH-1:2*TTL_WIDTH];

  assign full    = (count_q == FULL_LVL);
  assign push    = in_valid && !full && !clear;
  assign count_d = clear ? '0
                 : count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, fire};

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) state_q <= S_IDLE;
    else                state_q <= state_d;
  end

  // State reflects what the FIFO will hold after this edge, so a word pushed
  // while running is eligible to fire on the very next edge.
  always_comb begin
    state_d = S_IDLE;
    if (clear || !run)        state_d = S_IDLE;
    else if (count_d == '0)   state_d = S_ARMED;
    else                      state_d = S_WAIT;
  end

  always_comb begin
    fire = 1'b0;
    late = 1'b0;
    if (state_q == S_WAIT && run && !clear && count_q != '0 && head_ts <= time_q) begin
      fire = 1'b1;
      late = (head_ts < time_q);
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      time_q     <= '0;
      ttl_q      <= '0;
      late_q     <= 1'b0;
      late_cnt_q <= '0;
    end else begin
      count_q <= count_d;
      late_q  <= late;
      if (clear) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        time_q     <= '0;
        late_cnt_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fire) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
          ttl_q    <= (ttl_q & ~head_mask) | (head_val & head_mask);
        end
        if (run) time_q <= time_q + 1'b1;
        if (late && late_cnt_q != 16'hFFFF) late_cnt_q <= late_cnt_q + 16'd1;
      end
    end
  end

  assign in_ready   = !full;
  assign ttl_out    = ttl_q;
  assign time_now   = time_q;
  assign fifo_level = count_q;
  assign busy       = (count_q != '0);
  assign late_pulse = late_q;
  assign late_count = late_cnt_q;
endmodule
